// File: rtl/cnn_pkg.sv
// Shared defaults and encodings for the CNN convolution datapath stages.
package cnn_pkg;

   localparam int CNN_WIDTH  = 480;
   localparam int CNN_HEIGHT = 272;
   localparam int CNN_DEPTH  = CNN_WIDTH * CNN_HEIGHT;
   localparam int CNN_ADDR_W = 17;
   localparam int CNN_DATA_W = 24;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_RUN  = 2'd1,
      WR_DONE = 2'd2
   } wr_state_t;

endpackage

// File: rtl/cnn_sync_fifo.sv
// Small synchronous FIFO shared by CNN stages; head is read straight from storage
// so a word pushed this cycle is visible at rdata only from the next cycle.
module cnn_sync_fifo #(
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            iClk,
   input  logic                            iRst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [DATA_W-1:0]               wdata,
   output logic [DATA_W-1:0]               rdata,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH):0]     count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop_ok;

   always_comb begin
      pop_ok   = pop && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/conv_result_writer.sv
// Write-back of convolution results into the output frame BRAM in raster order.
//   state   | meaning
//   WR_IDLE | waiting for enable; entering RUN clears the error flag
//   WR_RUN  | accepting results and writing them whenever the BRAM port is granted
//   WR_DONE | last pixel written; oFrameDone high for this single cycle
module conv_result_writer
   import cnn_pkg::*;
#(
   parameter int DATA_W     = CNN_DATA_W,
   parameter int ADDR_W     = CNN_ADDR_W,
   parameter int WIDTH      = CNN_WIDTH,
   parameter int HEIGHT     = CNN_HEIGHT,
   parameter int DEPTH      = CNN_DEPTH,
   parameter int BASE_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEn,
   input  logic              iValid,
   input  logic [DATA_W-1:0] iData,
   output logic              oBusy,
   input  logic              iGrant,
   output logic              oCs,
   output logic              oWe,
   output logic [ADDR_W-1:0] oAddr,
   output logic [DATA_W-1:0] oData,
   output logic              oFrameDone,
   output logic              oErr
);

   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);
   localparam logic [CNT_W-1:0]  BUSY_LVL   = CNT_W'(FIFO_DEPTH - 1);

   wr_state_t         state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              push, wr, last_px, full, empty;
   logic [CNT_W-1:0]  count, cnt_nxt;
   logic [DATA_W-1:0] head;

   cnn_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .iClk  (iClk),
      .iRst  (iRst),
      .push  (push),
      .pop   (wr),
      .wdata (iData),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      wr      = iEn && (state_q == WR_RUN) && !empty && iGrant;
      push    = iEn && iValid && (state_q == WR_RUN) && (!full || wr);
      last_px = wr && (col_q == LAST_COL) && (row_q == LAST_ROW) && (addr_q == LAST_ADDR);
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      err_d   = err_q;
      done_d  = 1'b0;
      if (iEn) begin
         case (state_q)
            WR_IDLE: begin
               state_d = WR_RUN;
               err_d   = 1'b0;
            end
            WR_RUN:  if (last_px) state_d = WR_DONE;
            default: state_d = WR_IDLE;
         endcase
         if (wr) begin
            if (last_px) begin
               col_d  = '0;
               row_d  = '0;
               addr_d = FIRST_ADDR;
            end else if (col_q == LAST_COL) begin
               col_d  = '0;
               row_d  = row_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end else begin
               col_d  = col_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         // A strobe that is not pushed was either dropped on a full FIFO or arrived outside RUN.
         if (iValid && !push) err_d = 1'b1;
         done_d = last_px;
      end
      cnt_nxt = count + CNT_W'(push) - CNT_W'(wr);
      busy_d  = (cnt_nxt >= BUSY_LVL) || (state_d != WR_RUN);
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= WR_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= FIRST_ADDR;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign oCs        = wr;
   assign oWe        = wr;
   assign oAddr      = addr_q;
   assign oData      = head;
   assign oBusy      = busy_q;
   assign oFrameDone = done_q;
   assign oErr       = err_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer on a 4x3 frame based at address 16.
module tb_conv_result_writer;

   localparam int DW = 24;
   localparam int AW = 17;

   logic          iClk = 1'b0;
   logic          iRst = 1'b0;
   logic          iEn = 1'b0;
   logic          iValid = 1'b0;
   logic          iGrant = 1'b1;
   logic [DW-1:0] iData = '0;
   logic          oBusy, oCs, oWe, oFrameDone, oErr;
   logic [AW-1:0] oAddr;
   logic [DW-1:0] oData;

   always #5 iClk = ~iClk;

   conv_result_writer #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .WIDTH      (4),
      .HEIGHT     (3),
      .DEPTH      (12),
      .BASE_ADDR  (16),
      .FIFO_DEPTH (4)
   ) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iEn        (iEn),
      .iValid     (iValid),
      .iData      (iData),
      .oBusy      (oBusy),
      .iGrant     (iGrant),
      .oCs        (oCs),
      .oWe        (oWe),
      .oAddr      (oAddr),
      .oData      (oData),
      .oFrameDone (oFrameDone),
      .oErr       (oErr)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [AW-1:0] wa [$];
   logic [DW-1:0] wd [$];
   int            wc [$];
   int            dc [$];

   always @(posedge iClk) cyc <= cyc + 1;

   always @(negedge iClk) begin
      if (oWe) begin
         wa.push_back(oAddr);
         wd.push_back(oData);
         wc.push_back(cyc);
      end
      if (oFrameDone) dc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic clr();
      wa.delete();
      wd.delete();
      wc.delete();
      dc.delete();
   endtask

   // Producer reacts to oBusy one cycle late, so one push can be in flight.
   task automatic send(input int first, input int n, input int max_cyc, output int sent);
      logic b, prev_b;
      prev_b = 1'b0;
      sent   = 0;
      for (int k = 0; k < max_cyc && sent < n; k++) begin
         b = oBusy;
         if (!prev_b) begin
            iValid = 1'b1;
            iData  = DW'(first + sent);
            sent++;
         end else begin
            iValid = 1'b0;
         end
         step();
         prev_b = b;
      end
      iValid = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output logic found);
      int k;
      found = 1'b0;
      k = 0;
      while (!found && k < max_cyc) begin
         if (oFrameDone) found = 1'b1;
         else begin
            step();
            k++;
         end
      end
   endtask

   task automatic chk_wr(input string tag, input int d0, input int a0, input int n);
      chk({tag, "_cnt"}, wa.size(), n);
      for (int i = 0; i < n && i < wa.size(); i++) begin
         chk({tag, "_addr"}, wa[i], a0 + i);
         chk({tag, "_data"}, wd[i], d0 + i);
      end
   endtask

   initial begin
      int   sent;
      logic found;

      repeat (3) step();
      chk("rst_cs", oCs, 0);
      chk("rst_we", oWe, 0);
      chk("rst_addr", oAddr, 16);
      chk("rst_data", oData, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oFrameDone, 0);
      chk("rst_err", oErr, 0);
      iRst = 1'b1;
      iEn  = 1'b1;
      step();

      // full frame with the port always granted
      clr();
      send(1, 12, 40, sent);
      chk("f1_sent", sent, 12);
      wait_done(10, found);
      chk("f1_done_seen", found, 1);
      repeat (3) step();
      chk_wr("f1", 1, 16, 12);
      chk("f1_done_cnt", dc.size(), 1);
      if (dc.size() > 0 && wc.size() == 12) chk("f1_done_cyc", dc[0], wc[11] + 1);
      chk("f1_err", oErr, 0);

      // grant withheld: FIFO fills to four, then drains back-to-back
      clr();
      iGrant = 1'b0;
      send(101, 8, 8, sent);
      chk("hold_accept", sent, 4);
      chk("hold_busy", oBusy, 1);
      chk("hold_nowr", wa.size(), 0);
      iGrant = 1'b1;
      repeat (6) step();
      chk_wr("drain", 101, 16, 4);
      if (wc.size() == 4) chk("drain_consec", wc[3] - wc[0], 3);
      chk("drain_busy", oBusy, 0);
      chk("drain_err", oErr, 0);

      // overflow while full and ungranted
      clr();
      iGrant = 1'b0;
      send(105, 4, 8, sent);
      chk("ovf_busy", oBusy, 1);
      iValid = 1'b1;
      iData  = 24'h000BAD;
      step();
      iValid = 1'b0;
      chk("ovf_err", oErr, 1);
      repeat (3) step();
      chk("ovf_sticky", oErr, 1);
      iGrant = 1'b1;
      repeat (6) step();
      chk_wr("ovf_drain", 105, 20, 4);
      chk("ovf_sticky2", oErr, 1);
      clr();
      send(109, 4, 20, sent);
      wait_done(10, found);
      chk("f2_done_seen", found, 1);
      repeat (3) step();
      chk_wr("f2_tail", 109, 24, 4);
      chk("err_clear", oErr, 0);

      // enable dropped mid-row after col 2 is written
      clr();
      send(201, 3, 10, sent);
      repeat (2) step();
      chk("en_pre_cnt", wa.size(), 3);
      iEn    = 1'b0;
      iValid = 1'b1;
      iData  = 24'd999;
      repeat (5) step();
      chk("en_frozen_nowr", wa.size(), 3);
      chk("en_frozen_addr", oAddr, 19);
      chk("en_frozen_err", oErr, 0);
      iValid = 1'b0;
      iEn    = 1'b1;
      send(204, 9, 20, sent);
      wait_done(10, found);
      chk("f3_done_seen", found, 1);
      repeat (3) step();
      chk_wr("en_resume", 201, 16, 12);

      // reset in the middle of a frame
      clr();
      send(301, 7, 20, sent);
      repeat (2) step();
      chk("mid_cnt", wa.size(), 7);
      iRst = 1'b0;
      #1;
      chk("mrst_addr", oAddr, 16);
      chk("mrst_data", oData, 0);
      chk("mrst_we", oWe, 0);
      chk("mrst_cs", oCs, 0);
      chk("mrst_busy", oBusy, 0);
      chk("mrst_err", oErr, 0);
      chk("mrst_done", oFrameDone, 0);
      repeat (2) step();
      iRst = 1'b1;
      step();
      clr();
      send(401, 12, 40, sent);
      wait_done(10, found);
      chk("f4_done_seen", found, 1);

      // strobes in DONE and then IDLE are rejected
      iValid = 1'b1;
      iData  = 24'd1;
      step();
      chk("done_valid_err", oErr, 1);
      step();
      chk("idle_valid_err", oErr, 1);
      iValid = 1'b0;
      repeat (3) step();
      chk("idle_valid_sticky", oErr, 1);
      chk_wr("f4", 401, 16, 12);
      chk("f4_done_cnt", dc.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
